vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 95 +++++++++
 tb/tb_vga_timing_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster position counter with registered sync/visible/end decodes.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int COORD_BITS = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ce,
    output logic [COORD_BITS-1:0] o_x,
    output logic [COORD_BITS-1:0] o_y,
    output logic                  o_hsync,
    output logic                  o_vsync,
    output logic                  o_visible,
    output logic                  o_line_end,
    output logic                  o_frame_end
);

    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_LO = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_HI = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int unsigned V_SYNC_LO = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_HI = V_VISIBLE + V_FRONT + V_SYNC;
    localparam int unsigned H_VIS_U   = H_VISIBLE;
    localparam int unsigned V_VIS_U   = V_VISIBLE;
    localparam int unsigned MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

    localparam logic [COORD_BITS-1:0] H_LAST = COORD_BITS'(H_TOTAL - 1);
    localparam logic [COORD_BITS-1:0] V_LAST = COORD_BITS'(V_TOTAL - 1);

    if (COORD_BITS < $clog2(MAX_TOTAL)) begin : g_cfg_err
        $error("vga_timing_gen: COORD_BITS too small for H_TOTAL/V_TOTAL");
    end

    logic [COORD_BITS-1:0] x_nxt;
    logic [COORD_BITS-1:0] y_nxt;
    logic [31:0]           x_ext;
    logic [31:0]           y_ext;
    logic                  hs_nxt;
    logic                  vs_nxt;
    logic                  vis_nxt;
    logic                  le_nxt;
    logic                  fe_nxt;

    // Decodes are taken from the next position so they land in the same cycle as o_x/o_y.
    always_comb begin
        x_nxt = o_x;
        y_nxt = o_y;
        if (i_ce) begin
            if (o_x == H_LAST) begin
                x_nxt = '0;
                y_nxt = (o_y == V_LAST) ? '0 : o_y + COORD_BITS'(1);
            end else begin
                x_nxt = o_x + COORD_BITS'(1);
            end
        end

        x_ext   = 32'(x_nxt);
        y_ext   = 32'(y_nxt);
        hs_nxt  = ((x_ext >= H_SYNC_LO) && (x_ext < H_SYNC_HI)) ? SYNC_POL : ~SYNC_POL;
        vs_nxt  = ((y_ext >= V_SYNC_LO) && (y_ext < V_SYNC_HI)) ? SYNC_POL : ~SYNC_POL;
        vis_nxt = (x_ext < H_VIS_U) && (y_ext < V_VIS_U);
        le_nxt  = (x_nxt == H_LAST);
        fe_nxt  = (x_nxt == H_LAST) && (y_nxt == V_LAST);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_x         <= '0;
            o_y         <= '0;
            o_hsync     <= ~SYNC_POL;
            o_vsync     <= ~SYNC_POL;
            o_visible   <= 1'b1;
            o_line_end  <= 1'b0;
            o_frame_end <= 1'b0;
        end else begin
            o_x         <= x_nxt;
            o_y         <= y_nxt;
            o_hsync     <= hs_nxt;
            o_vsync     <= vs_nxt;
            o_visible   <= vis_nxt;
            o_line_end  <= le_nxt;
            o_frame_end <= fe_nxt;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized self-checking bench for vga_timing_gen against a raster model.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic ce;

    logic [9:0] d_x, d_y;
    logic       d_hs, d_vs, d_vis, d_le, d_fe;
    logic [4:0] a_x, a_y;
    logic       a_hs, a_vs, a_vis, a_le, a_fe;
    logic [4:0] b_x, b_y;
    logic       b_hs, b_vs, b_vis, b_le, b_fe;

    vga_timing_gen u_def (
        .i_clk(clk), .i_rst(rst), .i_ce(ce),
        .o_x(d_x), .o_y(d_y), .o_hsync(d_hs), .o_vsync(d_vs),
        .o_visible(d_vis), .o_line_end(d_le), .o_frame_end(d_fe)
    );

    // Small raster: H 10+2+3+2=17, V 6+1+2+2=11.
    vga_timing_gen #(
        .H_VISIBLE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .SYNC_POL(1'b0), .COORD_BITS(5)
    ) u_sm0 (
        .i_clk(clk), .i_rst(rst), .i_ce(ce),
        .o_x(a_x), .o_y(a_y), .o_hsync(a_hs), .o_vsync(a_vs),
        .o_visible(a_vis), .o_line_end(a_le), .o_frame_end(a_fe)
    );

    vga_timing_gen #(
        .H_VISIBLE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .SYNC_POL(1'b1), .COORD_BITS(5)
    ) u_sm1 (
        .i_clk(clk), .i_rst(rst), .i_ce(ce),
        .o_x(b_x), .o_y(b_y), .o_hsync(b_hs), .o_vsync(b_vs),
        .o_visible(b_vis), .o_line_end(b_le), .o_frame_end(b_fe)
    );

    int dx, dy, sx, sy;
    int checks = 0;
    int passed = 0;

    function automatic logic [24:0] exp_d();
        logic hs;
        logic vs;
        hs = (dx >= 656 && dx < 752) ? 1'b0 : 1'b1;
        vs = (dy >= 490 && dy < 492) ? 1'b0 : 1'b1;
        return {10'(dx), 10'(dy), hs, vs, (dx < 640 && dy < 480), (dx == 799), (dx == 799 && dy == 524)};
    endfunction

    function automatic logic [14:0] exp_s(input logic pol);
        logic hs;
        logic vs;
        hs = (sx >= 12 && sx < 15) ? pol : ~pol;
        vs = (sy >= 7 && sy < 9) ? pol : ~pol;
        return {5'(sx), 5'(sy), hs, vs, (sx < 10 && sy < 6), (sx == 16), (sx == 16 && sy == 10)};
    endfunction

    task automatic step(input logic c, input logic r);
        @(negedge clk);
        ce  = c;
        rst = r;
        @(posedge clk);
        #1;
        if (r) begin
            dx = 0; dy = 0; sx = 0; sy = 0;
        end else if (c) begin
            dx = (dx + 1) % 800;
            if (dx == 0) dy = (dy + 1) % 525;
            sx = (sx + 1) % 17;
            if (sx == 0) sy = (sy + 1) % 11;
        end
    endtask

    task automatic test_reset();
        step($urandom_range(0, 1) == 1, 1'b1);
        step($urandom_range(0, 1) == 1, 1'b1);
        checks++;
        if ({d_x, d_y, d_hs, d_vs, d_vis, d_le, d_fe} !== {10'd0, 10'd0, 5'b11100})
            $display("FAIL reset_def: got %h want %h", {d_x, d_y, d_hs, d_vs, d_vis, d_le, d_fe}, {10'd0, 10'd0, 5'b11100});
        else passed++;
        checks++;
        if ({b_x, b_y, b_hs, b_vs, b_vis, b_le, b_fe} !== {5'd0, 5'd0, 5'b00100})
            $display("FAIL reset_pol1: got %h want %h", {b_x, b_y, b_hs, b_vs, b_vis, b_le, b_fe}, {5'd0, 5'd0, 5'b00100});
        else passed++;
    endtask

    task automatic test_line();
        int n_le, n_hs, n_vis;
        n_le = 0; n_hs = 0; n_vis = 0;
        step(1'b1, 1'b1);
        for (int i = 0; i < 800; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if ({d_x, d_y, d_hs, d_vs, d_vis, d_le, d_fe} !== exp_d())
                $display("FAIL line_state: got %h want %h", {d_x, d_y, d_hs, d_vs, d_vis, d_le, d_fe}, exp_d());
            else passed++;
            if (d_le) n_le++;
            if (!d_hs) n_hs++;
            if (d_vis) n_vis++;
        end
        checks++;
        if (n_le != 1) $display("FAIL line_end_count: got %0d want 1", n_le); else passed++;
        checks++;
        if (n_hs != 96) $display("FAIL hsync_width: got %0d want 96", n_hs); else passed++;
        checks++;
        if (n_vis != 640) $display("FAIL visible_width: got %0d want 640", n_vis); else passed++;
        checks++;
        if ({d_x, d_y} !== {10'd0, 10'd1}) $display("FAIL line_wrap: got %h want %h", {d_x, d_y}, {10'd0, 10'd1});
        else passed++;
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1);
        for (int i = 0; i < 7 * 17 + 14; i++) step(1'b1, 1'b0);
        checks++;
        if ({a_x, a_y, a_hs, a_vs} !== {5'd14, 5'd7, 2'b00})
            $display("FAIL mid_pos: got %h want %h", {a_x, a_y, a_hs, a_vs}, {5'd14, 5'd7, 2'b00});
        else passed++;
        step(1'b1, 1'b1);
        checks++;
        if ({a_x, a_y, a_hs, a_vs, a_vis, a_le, a_fe} !== {5'd0, 5'd0, 5'b11100})
            $display("FAIL mid_reset: got %h want %h", {a_x, a_y, a_hs, a_vs, a_vis, a_le, a_fe}, {5'd0, 5'd0, 5'b11100});
        else passed++;
        checks++;
        if ({d_x, d_y} !== 20'd0) $display("FAIL mid_reset_def: got %h want 0", {d_x, d_y}); else passed++;
        step(1'b1, 1'b0);
        checks++;
        if ({a_x, a_y} !== {5'd1, 5'd0}) $display("FAIL mid_resume: got %h want %h", {a_x, a_y}, {5'd1, 5'd0});
        else passed++;
    endtask

    task automatic test_frame();
        int n_vs0, n_vs1, n_fe, n_hs1;
        n_vs0 = 0; n_vs1 = 0; n_fe = 0; n_hs1 = 0;
        step(1'b1, 1'b1);
        for (int i = 0; i < 17 * 11; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if ({a_x, a_y, a_hs, a_vs, a_vis, a_le, a_fe} !== exp_s(1'b0))
                $display("FAIL frame_pol0: got %h want %h", {a_x, a_y, a_hs, a_vs, a_vis, a_le, a_fe}, exp_s(1'b0));
            else passed++;
            checks++;
            if ({b_x, b_y, b_hs, b_vs, b_vis, b_le, b_fe} !== exp_s(1'b1))
                $display("FAIL frame_pol1: got %h want %h", {b_x, b_y, b_hs, b_vs, b_vis, b_le, b_fe}, exp_s(1'b1));
            else passed++;
            if (!a_vs) n_vs0++;
            if (b_vs) n_vs1++;
            if (b_hs) n_hs1++;
            if (a_fe) n_fe++;
        end
        checks++;
        if (n_vs0 != 34) $display("FAIL vsync_width: got %0d want 34", n_vs0); else passed++;
        checks++;
        if (n_vs1 != 34) $display("FAIL vsync_width_pol1: got %0d want 34", n_vs1); else passed++;
        checks++;
        if (n_hs1 != 33) $display("FAIL hsync_count_pol1: got %0d want 33", n_hs1); else passed++;
        checks++;
        if (n_fe != 1) $display("FAIL frame_end_count: got %0d want 1", n_fe); else passed++;
        checks++;
        if ({a_x, a_y} !== 10'd0) $display("FAIL frame_wrap: got %h want 0", {a_x, a_y}); else passed++;
    endtask

    task automatic test_ce_pattern();
        step(1'b1, 1'b1);
        for (int i = 0; i < 400; i++) begin
            step((i % 4) == 0, 1'b0);
            checks++;
            if ({d_x, d_y, d_hs, d_vs, d_vis, d_le, d_fe} !== exp_d())
                $display("FAIL ce_def: got %h want %h", {d_x, d_y, d_hs, d_vs, d_vis, d_le, d_fe}, exp_d());
            else passed++;
            checks++;
            if ({a_x, a_y, a_hs, a_vs, a_vis, a_le, a_fe} !== exp_s(1'b0))
                $display("FAIL ce_small: got %h want %h", {a_x, a_y, a_hs, a_vs, a_vis, a_le, a_fe}, exp_s(1'b0));
            else passed++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);
            checks++;
            if ({d_x, d_y, d_hs, d_vs, d_vis, d_le, d_fe} !== exp_d())
                $display("FAIL rand_def: got %h want %h", {d_x, d_y, d_hs, d_vs, d_vis, d_le, d_fe}, exp_d());
            else passed++;
            checks++;
            if ({a_x, a_y, a_hs, a_vs, a_vis, a_le, a_fe} !== exp_s(1'b0))
                $display("FAIL rand_pol0: got %h want %h", {a_x, a_y, a_hs, a_vs, a_vis, a_le, a_fe}, exp_s(1'b0));
            else passed++;
            checks++;
            if ({b_x, b_y, b_hs, b_vs, b_vis, b_le, b_fe} !== exp_s(1'b1))
                $display("FAIL rand_pol1: got %h want %h", {b_x, b_y, b_hs, b_vs, b_vis, b_le, b_fe}, exp_s(1'b1));
            else passed++;
        end
    endtask

    initial begin
        rst = 1'b1;
        ce  = 1'b0;
        dx = 0; dy = 0; sx = 0; sy = 0;
        test_reset();
        test_line();
        test_reset_mid();
        test_frame();
        test_ce_pattern();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
